ysyx_23060332_wbu: RTL and testbench
====================================

# ysyx_23060332_wbu

Write-back unit for the single-issue NPC core. It sits between the EXU/LSU and the register file. It accepts one retiring instruction per handshake and, for loads, waits for memory return data, then extracts and extends it. It then drives the register file's single write port (`reg_wen`/`waddr`/`wdata`) for exactly one cycle. It also reports the pending destination register to the IDU for hazard checks and emits a commit pulse for difftest.

## Interface
- `XLEN`, 32: data width.
- `RW`, 5: register address width.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-low (asserted at 0).
- `exu_valid` in 1: EXU presents a retiring instruction.
- `exu_ready` out 1: WBU can accept this cycle.
- `exu_rd` in RW: destination register.
- `exu_wen` in 1: instruction writes `rd`.
- `exu_wdata` in XLEN: ALU/jump result; ignored for loads.
- `exu_is_load` in 1: instruction is a load.
- `exu_ld_func` in 3: load funct3.
- `exu_addr_lo` in 2: low bits of the load address.
- `exu_pc` in XLEN: instruction PC.
- `lsu_rvalid` in 1: load data valid, one-cycle pulse.
- `lsu_rdata` in XLEN: raw aligned memory word.
- `reg_wen` out 1: register file write enable.
- `waddr` out RW: register file write address.
- `wdata` out XLEN: register file write data.
- `commit_valid` out 1: one-cycle retire pulse.
- `commit_pc` out XLEN: PC of the retiring instruction.
- `ld_err` out 1: one-cycle pulse on an illegal load funct3.
- `pend_valid` out 1: a write to `pend_rd` is still outstanding.
- `pend_rd` out RW: outstanding destination register.

## Operation
- FSM states: IDLE, WAIT_LD, WRITE.
- Handshake rules:
  - Accept fires when `exu_valid & exu_ready`.
  - `exu_ready` = (state != WAIT_LD) and rst deasserted.
  - Fields are captured only on accept.
- Transitions:
  - IDLE + accept, non-load → WRITE.
  - IDLE + accept, load → WAIT_LD.
  - WAIT_LD + `lsu_rvalid` → WRITE; load data is formatted and latched.
  - WAIT_LD without `lsu_rvalid` → stay in WAIT_LD; there is no timeout.
  - WRITE + accept → WRITE or WAIT_LD (back-to-back, same rules as IDLE).
  - WRITE without accept → IDLE.
- In WRITE: `reg_wen` = captured `wen` & (rd != 0), `waddr` = rd, `wdata` = result, and `commit_valid` = 1. Writes to x0 are always suppressed, but they still commit.
- Outside WRITE, `reg_wen` and `commit_valid` are 0. `waddr` and `wdata` hold their last values.
- Load formatting (byte index b = `exu_addr_lo`, half index h = `exu_addr_lo[1]`):
  - 000 lb: sign-extended byte b.
  - 001 lh: sign-extended half h.
  - 010 lw: full word; `addr_lo` ignored.
  - 100 lbu: zero-extended byte b.
  - 101 lhu: zero-extended half h.
  - 011/110/111: `wdata` = 0, `reg_wen` = 0, `ld_err` pulses in the WRITE cycle, and the instruction still commits.
- `lsu_rvalid` is sampled only in WAIT_LD. A pulse in any other state is ignored and changes no state.
- `pend_valid` = 1 when (state WAIT_LD) or (state WRITE with `reg_wen` = 1).
- `pend_rd` = captured rd. The IDU must stall a reader of `pend_rd` while `pend_valid` = 1.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All outputs go to 0: `reg_wen`, `waddr`, `wdata`, `commit_valid`, `commit_pc`, `ld_err`, `pend_valid`, `pend_rd`, `exu_ready`.
  - A load in flight is dropped; there is no write and no commit.
  - After release, `exu_ready` = 1 in the first cycle.

## Timing
- Non-load accepted in cycle N: `reg_wen`/`commit_valid` high in cycle N+1. The register file updates on the edge ending N+1.
- Load accepted in cycle N: WAIT_LD from N+1. `lsu_rvalid` in cycle M ≥ N+1 gives WRITE in M+1. Minimum load latency is 2 cycles.
- `lsu_rvalid` in the acceptance cycle N is ignored.
- Back-to-back non-loads sustain 1 write per cycle. `reg_wen` stays high across consecutive WRITE cycles with updated `waddr`/`wdata`.
- All outputs except `exu_ready` are registered. `exu_ready` is combinational from state only, never from `exu_valid`.

## Test plan
- Reset then ALU op (rd=5, wdata=0x1234_5678, wen=1) → next cycle `reg_wen`=1, `waddr`=5, `wdata`=0x12345678, `commit_valid`=1, `commit_pc`=exu_pc; following cycle `reg_wen`=0.
- rd=0 wen=1 wdata=0xFFFF_FFFF → `reg_wen`=0, `commit_valid`=1, `pend_valid`=0.
- Loads with `lsu_rdata`=0x80F1_7F82, each with `lsu_rvalid` 3 cycles after accept (`exu_ready`=0 while waiting) → write 4 cycles after accept:
  - lb, addr_lo=0 → 0xFFFF_FF82.
  - lbu, addr_lo=1 → 0x0000_007F.
  - lh, addr_lo=2 → 0xFFFF_80F1.
  - lhu, addr_lo=2 → 0x0000_80F1.
  - lw → 0x80F1_7F82.
- Five ALU ops on consecutive cycles (`exu_valid` held high) → five consecutive `reg_wen` cycles, in order, no bubbles; stray `lsu_rvalid` pulses during them → no effect.
- Load with funct3=011 → `ld_err`=1 and `commit_valid`=1 in the same cycle, `reg_wen`=0.
- Load accepted, `rst` driven low mid-WAIT_LD, released, then `lsu_rvalid` pulsed → outputs immediately 0, no write, no commit, `exu_ready`=1 after release.

Source files
------------

// File: rtl/ysyx_23060332_wbu_if.sv
// rtl/ysyx_23060332_wbu_if.sv - EXU/LSU/regfile/IDU bundle seen by the write-back unit
interface ysyx_23060332_wbu_if #(
  parameter int XLEN = 32,
  parameter int RW   = 5
);
  // retiring instruction from EXU
  logic            exu_valid;
  logic            exu_ready;
  logic [RW-1:0]   exu_rd;
  logic            exu_wen;
  logic [XLEN-1:0] exu_wdata;
  logic            exu_is_load;
  logic [2:0]      exu_ld_func;
  logic [1:0]      exu_addr_lo;
  logic [XLEN-1:0] exu_pc;
  // load return from LSU
  logic            lsu_rvalid;
  logic [XLEN-1:0] lsu_rdata;
  // register file write port
  logic            reg_wen;
  logic [RW-1:0]   waddr;
  logic [XLEN-1:0] wdata;
  // commit / error / hazard reporting
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic            ld_err;
  logic            pend_valid;
  logic [RW-1:0]   pend_rd;

  modport master (
    output exu_valid, exu_rd, exu_wen, exu_wdata, exu_is_load, exu_ld_func,
           exu_addr_lo, exu_pc, lsu_rvalid, lsu_rdata,
    input  exu_ready, reg_wen, waddr, wdata, commit_valid, commit_pc, ld_err,
           pend_valid, pend_rd
  );

  modport slave (
    input  exu_valid, exu_rd, exu_wen, exu_wdata, exu_is_load, exu_ld_func,
           exu_addr_lo, exu_pc, lsu_rvalid, lsu_rdata,
    output exu_ready, reg_wen, waddr, wdata, commit_valid, commit_pc, ld_err,
           pend_valid, pend_rd
  );
endinterface

// File: rtl/ysyx_23060332_wbu.sv
// rtl/ysyx_23060332_wbu.sv - write-back unit: load formatting, single-cycle regfile write, commit pulse
module ysyx_23060332_wbu #(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  ysyx_23060332_wbu_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, WAIT_LD, WRITE} state_t;

  state_t          state;
  logic [RW-1:0]   rd_q;
  logic            wen_q;
  logic [2:0]      func_q;
  logic [1:0]      lo_q;
  logic [XLEN-1:0] pc_q;

  logic            accept;
  logic            rd_nz;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;
  logic            ld_legal;

  // Ready depends only on state so the EXU never sees a valid->ready loop.
  assign bus.exu_ready = (state != WAIT_LD) && rst;
  assign accept        = bus.exu_valid && bus.exu_ready;
  assign rd_nz         = |bus.exu_rd;

  // Select and extend the returned memory word according to the captured funct3/offset.
  always_comb begin
    ld_byte  = 8'h00;
    ld_half  = 16'h0000;
    ld_data  = '0;
    ld_legal = 1'b1;
    case (lo_q)
      2'd0:    ld_byte = bus.lsu_rdata[7:0];
      2'd1:    ld_byte = bus.lsu_rdata[15:8];
      2'd2:    ld_byte = bus.lsu_rdata[23:16];
      default: ld_byte = bus.lsu_rdata[31:24];
    endcase
    ld_half = lo_q[1] ? bus.lsu_rdata[31:16] : bus.lsu_rdata[15:0];
    case (func_q)
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b010:  ld_data = bus.lsu_rdata;
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_legal = 1'b0;
    endcase
  end

  // FSM with registered write-port, commit and hazard outputs; accept has priority over retiring.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      rd_q             <= '0;
      wen_q            <= 1'b0;
      func_q           <= 3'b000;
      lo_q             <= 2'b00;
      pc_q             <= '0;
      bus.reg_wen      <= 1'b0;
      bus.waddr        <= '0;
      bus.wdata        <= '0;
      bus.commit_valid <= 1'b0;
      bus.commit_pc    <= '0;
      bus.ld_err       <= 1'b0;
      bus.pend_valid   <= 1'b0;
      bus.pend_rd      <= '0;
    end else begin
      bus.reg_wen      <= 1'b0;
      bus.commit_valid <= 1'b0;
      bus.ld_err       <= 1'b0;
      if (accept) begin
        rd_q        <= bus.exu_rd;
        wen_q       <= bus.exu_wen;
        func_q      <= bus.exu_ld_func;
        lo_q        <= bus.exu_addr_lo;
        pc_q        <= bus.exu_pc;
        bus.pend_rd <= bus.exu_rd;
        if (bus.exu_is_load) begin
          state          <= WAIT_LD;
          bus.pend_valid <= 1'b1;
        end else begin
          // x0 writes are dropped but the instruction still retires.
          state            <= WRITE;
          bus.reg_wen      <= bus.exu_wen && rd_nz;
          bus.waddr        <= bus.exu_rd;
          bus.wdata        <= bus.exu_wdata;
          bus.commit_valid <= 1'b1;
          bus.commit_pc    <= bus.exu_pc;
          bus.pend_valid   <= bus.exu_wen && rd_nz;
        end
      end else begin
        case (state)
          WAIT_LD: begin
            if (bus.lsu_rvalid) begin
              state            <= WRITE;
              bus.reg_wen      <= ld_legal && wen_q && (|rd_q);
              bus.waddr        <= rd_q;
              bus.wdata        <= ld_legal ? ld_data : '0;
              bus.commit_valid <= 1'b1;
              bus.commit_pc    <= pc_q;
              bus.ld_err       <= !ld_legal;
              bus.pend_valid   <= ld_legal && wen_q && (|rd_q);
            end
          end
          WRITE: begin
            state          <= IDLE;
            bus.pend_valid <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060332_wbu.sv
// tb/tb_ysyx_23060332_wbu.sv - directed self-checking bench for the write-back unit
module tb_ysyx_23060332_wbu;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  ysyx_23060332_wbu_if #(.XLEN(32), .RW(5)) bus ();

  ysyx_23060332_wbu #(.XLEN(32), .RW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string tag, input logic [2:0] func, input logic [1:0] lo,
                         input logic [31:0] exp, input logic err);
    bus.exu_valid   = 1'b1;
    bus.exu_is_load = 1'b1;
    bus.exu_ld_func = func;
    bus.exu_addr_lo = lo;
    bus.exu_rd      = 5'd7;
    bus.exu_wen     = 1'b1;
    bus.exu_pc      = 32'h8000_0100;
    bus.exu_wdata   = 32'hDEAD_BEEF;
    bus.lsu_rvalid  = 1'b1;
    bus.lsu_rdata   = 32'h1111_1111;
    step();
    bus.exu_valid   = 1'b0;
    bus.exu_is_load = 1'b0;
    bus.lsu_rvalid  = 1'b0;
    chk({tag, "_ready_wait"}, bus.exu_ready, 0);
    chk({tag, "_pend_wait"}, bus.pend_valid, 1);
    step();
    step();
    bus.lsu_rvalid = 1'b1;
    bus.lsu_rdata  = 32'h80F1_7F82;
    step();
    bus.lsu_rvalid = 1'b0;
    chk({tag, "_reg_wen"}, bus.reg_wen, {31'd0, !err});
    chk({tag, "_wdata"}, bus.wdata, exp);
    chk({tag, "_waddr"}, bus.waddr, 7);
    chk({tag, "_commit"}, bus.commit_valid, 1);
    chk({tag, "_commit_pc"}, bus.commit_pc, 32'h8000_0100);
    chk({tag, "_ld_err"}, bus.ld_err, {31'd0, err});
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.exu_valid   = 1'b0;
    bus.exu_rd      = '0;
    bus.exu_wen     = 1'b0;
    bus.exu_wdata   = '0;
    bus.exu_is_load = 1'b0;
    bus.exu_ld_func = 3'b000;
    bus.exu_addr_lo = 2'b00;
    bus.exu_pc      = '0;
    bus.lsu_rvalid  = 1'b0;
    bus.lsu_rdata   = '0;
    #3 rst = 1'b0;
    step();
    step();
    chk("rst_ready", bus.exu_ready, 0);
    chk("rst_reg_wen", bus.reg_wen, 0);
    chk("rst_commit", bus.commit_valid, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_pend", bus.pend_valid, 0);
    rst = 1'b1;
    #1;
    chk("rel_ready", bus.exu_ready, 1);

    // single ALU op
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd5;
    bus.exu_wen   = 1'b1;
    bus.exu_wdata = 32'h1234_5678;
    bus.exu_pc    = 32'h8000_0000;
    step();
    bus.exu_valid = 1'b0;
    chk("alu_reg_wen", bus.reg_wen, 1);
    chk("alu_waddr", bus.waddr, 5);
    chk("alu_wdata", bus.wdata, 32'h1234_5678);
    chk("alu_commit", bus.commit_valid, 1);
    chk("alu_commit_pc", bus.commit_pc, 32'h8000_0000);
    chk("alu_pend", bus.pend_valid, 1);
    chk("alu_pend_rd", bus.pend_rd, 5);
    step();
    chk("alu_after_wen", bus.reg_wen, 0);
    chk("alu_after_commit", bus.commit_valid, 0);
    chk("alu_after_waddr_hold", bus.waddr, 5);

    // write to x0
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd0;
    bus.exu_wen   = 1'b1;
    bus.exu_wdata = 32'hFFFF_FFFF;
    bus.exu_pc    = 32'h8000_0004;
    step();
    bus.exu_valid = 1'b0;
    chk("x0_reg_wen", bus.reg_wen, 0);
    chk("x0_commit", bus.commit_valid, 1);
    chk("x0_pend", bus.pend_valid, 0);
    step();

    // loads on word 0x80F17F82
    do_load("lb0", 3'b000, 2'd0, 32'hFFFF_FF82, 1'b0);
    do_load("lbu1", 3'b100, 2'd1, 32'h0000_007F, 1'b0);
    do_load("lh2", 3'b001, 2'd2, 32'hFFFF_80F1, 1'b0);
    do_load("lhu2", 3'b101, 2'd2, 32'h0000_80F1, 1'b0);
    do_load("lw", 3'b010, 2'd3, 32'h80F1_7F82, 1'b0);
    do_load("bad011", 3'b011, 2'd0, 32'h0000_0000, 1'b1);

    // back-to-back ALU ops with stray load-return pulses
    bus.exu_valid = 1'b1;
    bus.exu_wen   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.exu_rd     = 5'(i + 1);
      bus.exu_wdata  = 32'h0000_0100 + 32'(i);
      bus.exu_pc     = 32'h8000_0200 + 32'(4 * i);
      bus.lsu_rvalid = (i % 2) == 0;
      bus.lsu_rdata  = 32'hBAD0_BAD0;
      step();
      chk($sformatf("b2b%0d_reg_wen", i), bus.reg_wen, 1);
      chk($sformatf("b2b%0d_waddr", i), bus.waddr, i + 1);
      chk($sformatf("b2b%0d_wdata", i), bus.wdata, 32'h0000_0100 + 32'(i));
      chk($sformatf("b2b%0d_ready", i), bus.exu_ready, 1);
    end
    bus.exu_valid  = 1'b0;
    bus.lsu_rvalid = 1'b0;
    step();
    chk("b2b_end_wen", bus.reg_wen, 0);
    chk("b2b_end_commit", bus.commit_valid, 0);

    // reset during WAIT_LD
    bus.exu_valid   = 1'b1;
    bus.exu_is_load = 1'b1;
    bus.exu_ld_func = 3'b010;
    bus.exu_rd      = 5'd9;
    bus.exu_wen     = 1'b1;
    step();
    bus.exu_valid   = 1'b0;
    bus.exu_is_load = 1'b0;
    chk("mid_ready_wait", bus.exu_ready, 0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_pend", bus.pend_valid, 0);
    chk("mid_rst_pend_rd", bus.pend_rd, 0);
    chk("mid_rst_waddr", bus.waddr, 0);
    chk("mid_rst_ready", bus.exu_ready, 0);
    step();
    rst = 1'b1;
    #1;
    chk("mid_rel_ready", bus.exu_ready, 1);
    bus.lsu_rvalid = 1'b1;
    bus.lsu_rdata  = 32'h5555_5555;
    step();
    bus.lsu_rvalid = 1'b0;
    chk("mid_no_write", bus.reg_wen, 0);
    chk("mid_no_commit", bus.commit_valid, 0);
    chk("mid_ready_idle", bus.exu_ready, 1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
